// File: rtl/cb_argmin.sv
// Streaming arg-min over Kt/Pt beats of Pt squared distances: a registered compare tree
// followed by a running-min register, with the result held under a valid/ready handshake.
module cb_argmin #(
  parameter int W  = 32,
  parameter int Kt = 32,
  parameter int Pt = 16,
  localparam int NB = Kt / Pt,
  localparam int BA = (NB > 1) ? $clog2(NB) : 1,
  localparam int IA = $clog2(Kt),
  localparam int TL = $clog2(Pt)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic            start,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [BA-1:0]   in_addr,
  input  logic [Pt*W-1:0] in_dist,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [IA-1:0]   out_idx,
  output logic [W-1:0]    out_dist,
  output logic            err
);
  localparam int NN = 2 * Pt - 1;
  localparam int DW = $clog2(TL + 2);

  typedef enum logic [1:0] {IDLE, ACC, DRN, OUT} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [BA-1:0] r_beatCnt;
  logic [DW-1:0] r_drnCnt;
  logic [W-1:0]  r_ndDist [NN];
  logic [IA-1:0] r_ndIdx  [NN];
  logic [TL:0]   r_lvlVld;
  logic [W-1:0]  r_minDist;
  logic [IA-1:0] r_minIdx;
  logic [W-1:0]  r_outDist;
  logic [IA-1:0] r_outIdx;
  logic          r_err;
  logic [IA-1:0] w_laneIdx [Pt];
  logic          w_accept;
  logic          w_init;
  logic          w_load;
  logic          w_errSet;
  logic          w_lastBeat;
  logic          w_drnDone;

  assign in_rdy     = (r_state == ACC);
  assign out_vld    = (r_state == OUT);
  assign out_idx    = r_outIdx;
  assign out_dist   = r_outDist;
  assign err        = r_err;
  assign w_lastBeat = (r_beatCnt == BA'(NB - 1));
  assign w_drnDone  = (r_drnCnt == DW'(TL + 1));

  always_comb begin
    for (int j = 0; j < Pt; j++) begin
      w_laneIdx[j] = IA'({in_addr, TL'(j)});
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else if (ena) begin
      r_state <= w_next;
    end
  end

  // A start inside a query wins over a beat in the same cycle: the beat is discarded.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_init   = 1'b0;
    w_load   = 1'b0;
    w_errSet = in_vld && !in_rdy;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_init = 1'b1;
          w_next = ACC;
        end
      end
      ACC: begin
        if (start) begin
          w_init = 1'b1;
        end else if (in_vld) begin
          w_accept = 1'b1;
          if (in_addr != r_beatCnt) w_errSet = 1'b1;
          if (w_lastBeat) w_next = DRN;
        end
      end
      DRN: begin
        if (start) begin
          w_init = 1'b1;
          w_next = ACC;
        end else if (w_drnDone) begin
          w_load = 1'b1;
          w_next = OUT;
        end
      end
      OUT: begin
        if (start) w_errSet = 1'b1;
        if (out_rdy) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beatCnt <= '0;
      r_drnCnt  <= '0;
      r_err     <= 1'b0;
    end else if (ena) begin
      if (w_errSet) r_err <= 1'b1;
      if (w_init) begin
        r_beatCnt <= '0;
      end else if (w_accept) begin
        r_beatCnt <= r_beatCnt + 1'b1;
      end
      if (r_state == DRN && !w_init) begin
        r_drnCnt <= r_drnCnt + 1'b1;
      end else begin
        r_drnCnt <= '0;
      end
    end
  end

  // Heap-ordered tree: leaves sit at Pt-1+lane, so the left child always holds lower indices.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < NN; n++) begin
        r_ndDist[n] <= '0;
        r_ndIdx[n]  <= '0;
      end
      r_lvlVld <= '0;
    end else if (ena) begin
      for (int j = 0; j < Pt; j++) begin
        r_ndDist[Pt-1+j] <= in_dist[j*W +: W];
        r_ndIdx[Pt-1+j]  <= w_laneIdx[j];
      end
      for (int n = 0; n < Pt - 1; n++) begin
        if (r_ndDist[2*n+2] < r_ndDist[2*n+1]) begin
          r_ndDist[n] <= r_ndDist[2*n+2];
          r_ndIdx[n]  <= r_ndIdx[2*n+2];
        end else begin
          r_ndDist[n] <= r_ndDist[2*n+1];
          r_ndIdx[n]  <= r_ndIdx[2*n+1];
        end
      end
      r_lvlVld <= w_init ? '0 : {w_accept, r_lvlVld[TL:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_minDist <= '0;
      r_minIdx  <= '0;
      r_outDist <= '0;
      r_outIdx  <= '0;
    end else if (ena) begin
      if (w_init) begin
        r_minDist <= '1;
        r_minIdx  <= '0;
      end else if (r_lvlVld[0] && (r_ndDist[0] < r_minDist)) begin
        r_minDist <= r_ndDist[0];
        r_minIdx  <= r_ndIdx[0];
      end
      if (w_load) begin
        r_outDist <= r_minDist;
        r_outIdx  <= r_minIdx;
      end
    end
  end
endmodule

// File: tb/tb_cb_argmin.sv
// Self-checking bench for cb_argmin: directed cases plus randomized queries scored
// against a flat scan of the codebook distances.
module tb_cb_argmin;
  localparam int W   = 32;
  localparam int Kt  = 32;
  localparam int Pt  = 16;
  localparam int NB  = Kt / Pt;
  localparam int BA  = 1;
  localparam int IA  = 5;
  localparam int TL  = 4;
  localparam int LAT = TL + 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            ena;
  logic            start;
  logic            in_vld;
  logic            in_rdy;
  logic [BA-1:0]   in_addr;
  logic [Pt*W-1:0] in_dist;
  logic            out_vld;
  logic            out_rdy;
  logic [IA-1:0]   out_idx;
  logic [W-1:0]    out_dist;
  logic            err;

  int            checks = 0;
  int            failures = 0;
  logic [W-1:0]  beatMem [NB][Pt];
  logic [IA-1:0] expIdx;
  logic [W-1:0]  expDist;

  always #5 clk = ~clk;

  cb_argmin #(.W(W), .Kt(Kt), .Pt(Pt)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_addr(in_addr), .in_dist(in_dist),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_idx(out_idx), .out_dist(out_dist),
    .err(err)
  );

  function automatic logic [Pt*W-1:0] pack(input int b);
    logic [Pt*W-1:0] v;
    for (int j = 0; j < Pt; j++) v[j*W +: W] = beatMem[b][j];
    return v;
  endfunction

  // Reference: scan all centroids in index order; strict '<' keeps the lowest index on ties.
  task automatic compute_expected();
    expDist = '1;
    expIdx  = '0;
    for (int k = 0; k < Kt; k++) begin
      if (beatMem[k/Pt][k%Pt] < expDist) begin
        expDist = beatMem[k/Pt][k%Pt];
        expIdx  = IA'(k);
      end
    end
  endtask

  task automatic fill_all(input logic [W-1:0] val);
    for (int b = 0; b < NB; b++)
      for (int j = 0; j < Pt; j++) beatMem[b][j] = val;
  endtask

  task automatic fill_case1();
    for (int j = 0; j < Pt; j++) begin
      beatMem[0][j] = W'(100 + j);
      beatMem[1][j] = W'(200 + j);
    end
    beatMem[1][5] = 7;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic applyStimulus(input int b);
    in_vld  = 1'b1;
    in_addr = BA'(b);
    in_dist = pack(b);
    @(negedge clk);
    in_vld  = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_vld && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_vld) lat = -1;
  endtask

  task automatic run_query(input int maxGap, output int lat);
    int g;
    pulse_start();
    for (int b = 0; b < NB; b++) begin
      g = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
      repeat (g) @(negedge clk);
      applyStimulus(b);
    end
    wait_result(lat);
  endtask

  task automatic take_result();
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks += 5;
    if (in_rdy !== 1'b0)  begin failures++; $display("[TB] FAIL reset_in_rdy: got %b expected 0", in_rdy); end
    if (out_vld !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_vld: got %b expected 0", out_vld); end
    if (out_idx !== '0)   begin failures++; $display("[TB] FAIL reset_out_idx: got %0d expected 0", out_idx); end
    if (out_dist !== '0)  begin failures++; $display("[TB] FAIL reset_out_dist: got %0d expected 0", out_dist); end
    if (err !== 1'b0)     begin failures++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    fill_case1();
    run_query(0, lat);
    checks += 3;
    if (lat !== LAT)    begin failures++; $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, LAT); end
    if (out_idx !== 21) begin failures++; $display("[TB] FAIL basic_idx: got %0d expected 21", out_idx); end
    if (out_dist !== 7) begin failures++; $display("[TB] FAIL basic_dist: got %0d expected 7", out_dist); end
    take_result();
    checks += 2;
    if (out_vld !== 1'b0) begin failures++; $display("[TB] FAIL basic_vld_drop: got %b expected 0", out_vld); end
    if (err !== 1'b0)     begin failures++; $display("[TB] FAIL basic_err: got %b expected 0", err); end
  endtask

  task automatic test_tie();
    int lat;
    fill_all(9);
    beatMem[0][3] = 5;
    beatMem[1][0] = 5;
    run_query(0, lat);
    checks += 2;
    if (out_idx !== 3)  begin failures++; $display("[TB] FAIL tie_beats_idx: got %0d expected 3", out_idx); end
    if (out_dist !== 5) begin failures++; $display("[TB] FAIL tie_beats_dist: got %0d expected 5", out_dist); end
    take_result();
    fill_all(9);
    beatMem[0][2] = 1;
    beatMem[0][9] = 1;
    run_query(0, lat);
    checks += 2;
    if (out_idx !== 2)  begin failures++; $display("[TB] FAIL tie_lanes_idx: got %0d expected 2", out_idx); end
    if (out_dist !== 1) begin failures++; $display("[TB] FAIL tie_lanes_dist: got %0d expected 1", out_dist); end
    take_result();
  endtask

  task automatic test_random();
    int lat;
    for (int it = 0; it < 8; it++) begin
      for (int b = 0; b < NB; b++)
        for (int j = 0; j < Pt; j++)
          beatMem[b][j] = (it % 2 == 1) ? W'($urandom_range(0, 12)) : W'($urandom);
      compute_expected();
      run_query(3, lat);
      checks += 3;
      if (lat !== LAT)         begin failures++; $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", it, lat, LAT); end
      if (out_idx !== expIdx)  begin failures++; $display("[TB] FAIL rand%0d_idx: got %0d expected %0d", it, out_idx, expIdx); end
      if (out_dist !== expDist) begin failures++; $display("[TB] FAIL rand%0d_dist: got %0d expected %0d", it, out_dist, expDist); end
      take_result();
    end
    checks++;
    if (err !== 1'b0) begin failures++; $display("[TB] FAIL rand_err: got %b expected 0", err); end
  endtask

  task automatic test_abort();
    int lat;
    fill_all(1);
    pulse_start();
    applyStimulus(0);
    pulse_start();
    checks += 3;
    if (in_rdy !== 1'b1)  begin failures++; $display("[TB] FAIL abort_in_rdy: got %b expected 1", in_rdy); end
    if (out_vld !== 1'b0) begin failures++; $display("[TB] FAIL abort_out_vld: got %b expected 0", out_vld); end
    if (err !== 1'b0)     begin failures++; $display("[TB] FAIL abort_err: got %b expected 0", err); end
    for (int j = 0; j < Pt; j++) begin
      beatMem[0][j] = W'(100 + $urandom_range(0, 900));
      beatMem[1][j] = W'(60 + $urandom_range(0, 900));
    end
    beatMem[1][14] = 50;
    applyStimulus(0);
    applyStimulus(1);
    wait_result(lat);
    checks += 3;
    if (lat !== LAT)     begin failures++; $display("[TB] FAIL abort_latency: got %0d expected %0d", lat, LAT); end
    if (out_idx !== 30)  begin failures++; $display("[TB] FAIL abort_idx: got %0d expected 30", out_idx); end
    if (out_dist !== 50) begin failures++; $display("[TB] FAIL abort_dist: got %0d expected 50", out_dist); end
    take_result();
  endtask

  task automatic test_ena_stall();
    int lat;
    fill_case1();
    pulse_start();
    applyStimulus(0);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    ena = 1'b1;
    applyStimulus(1);
    lat = 0;
    while (!out_vld && lat < 40) begin
      if (lat == 2) ena = 1'b0;
      if (lat == 5) ena = 1'b1;
      @(negedge clk);
      lat++;
    end
    ena = 1'b1;
    if (!out_vld) lat = -1;
    checks += 3;
    if (lat !== LAT + 3) begin failures++; $display("[TB] FAIL stall_latency: got %0d expected %0d", lat, LAT + 3); end
    if (out_idx !== 21)  begin failures++; $display("[TB] FAIL stall_idx: got %0d expected 21", out_idx); end
    if (out_dist !== 7)  begin failures++; $display("[TB] FAIL stall_dist: got %0d expected 7", out_dist); end
    take_result();
  endtask

  task automatic test_backpressure();
    int lat;
    for (int b = 0; b < NB; b++)
      for (int j = 0; j < Pt; j++) beatMem[b][j] = W'($urandom);
    compute_expected();
    run_query(1, lat);
    checks++;
    if (lat !== LAT) begin failures++; $display("[TB] FAIL bp_latency: got %0d expected %0d", lat, LAT); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({out_vld, in_rdy, out_idx, out_dist} !== {1'b1, 1'b0, expIdx, expDist}) begin
        failures++;
        $display("[TB] FAIL bp_hold%0d: got vld=%b rdy=%b idx=%0d dist=%0d expected vld=1 rdy=0 idx=%0d dist=%0d",
                 c, out_vld, in_rdy, out_idx, out_dist, expIdx, expDist);
      end
    end
    in_vld = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    checks += 2;
    if (err !== 1'b1) begin failures++; $display("[TB] FAIL bp_err: got %b expected 1", err); end
    if ({out_vld, out_idx, out_dist} !== {1'b1, expIdx, expDist}) begin
      failures++;
      $display("[TB] FAIL bp_after_drop: got vld=%b idx=%0d dist=%0d expected vld=1 idx=%0d dist=%0d",
               out_vld, out_idx, out_dist, expIdx, expDist);
    end
    take_result();
  endtask

  task automatic test_reset_mid();
    int  lat;
    logic sawVld;
    fill_case1();
    pulse_start();
    applyStimulus(0);
    applyStimulus(1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks += 3;
    if (out_vld !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_out_vld: got %b expected 0", out_vld); end
    if (err !== 1'b0)     begin failures++; $display("[TB] FAIL rstmid_err: got %b expected 0", err); end
    if (in_rdy !== 1'b0)  begin failures++; $display("[TB] FAIL rstmid_in_rdy: got %b expected 0", in_rdy); end
    @(negedge clk);
    rst = 1'b1;
    sawVld = 1'b0;
    repeat (8) begin
      @(negedge clk);
      sawVld |= out_vld;
    end
    checks++;
    if (sawVld !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_no_partial: got %b expected 0", sawVld); end
    run_query(2, lat);
    checks += 3;
    if (lat !== LAT)    begin failures++; $display("[TB] FAIL rstmid_latency: got %0d expected %0d", lat, LAT); end
    if (out_idx !== 21) begin failures++; $display("[TB] FAIL rstmid_idx: got %0d expected 21", out_idx); end
    if (out_dist !== 7) begin failures++; $display("[TB] FAIL rstmid_dist: got %0d expected 7", out_dist); end
    take_result();
  endtask

  task automatic test_all_ones();
    int lat;
    fill_all('1);
    run_query(0, lat);
    checks += 2;
    if (out_idx !== 0)             begin failures++; $display("[TB] FAIL ones_idx: got %0d expected 0", out_idx); end
    if (out_dist !== 32'hFFFFFFFF) begin failures++; $display("[TB] FAIL ones_dist: got %h expected ffffffff", out_dist); end
    take_result();
  endtask

  initial begin
    rst     = 1'b0;
    ena     = 1'b1;
    start   = 1'b0;
    in_vld  = 1'b0;
    in_addr = '0;
    in_dist = '0;
    out_rdy = 1'b0;
    test_reset();
    test_basic();
    test_tie();
    test_random();
    test_abort();
    test_ena_stall();
    test_backpressure();
    test_reset_mid();
    test_all_ones();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
